i2c_sensor_cfg_sequencer: RTL and testbench
===========================================

// Module: i2c_sensor_cfg_sequencer
// PURPOSE
//  Walks the sensor register-config LUT (24-bit entries: {reg_addr[15:0], value[7:0]}) from index 0 to LUT_SIZE-1.
//  Issues one I2C 16-bit-address register write per entry through a req/done handshake to the I2C byte master.
//  Inserts the power-up delay, a settle delay after the soft-reset register write (0x0103), and a fixed gap between writes.
//  Retries a write that got a NACK; reports done/error to the CMOS capture top level.
// PARAMETERS
//  IDX_W           9        width of LUT index and LUT size
//  INIT_DLY        500000   clk cycles to wait after reset release before the first write
//  SRST_DLY        250000   clk cycles to wait after a write to reg 16'h0103
//  GAP_DLY         100      clk cycles between consecutive writes, and before a retry
//  MAX_RETRY       3        attempts per entry before declaring an error (>=1)
//  DLY_W           20       delay counter width; must hold max(INIT_DLY, SRST_DLY)
// PORTS
//  clk          in   1      system clock
//  rst_n        in   1      asynchronous active-low reset
//  cfg_start    in   1      one-cycle pulse: rerun the config from index 0 (honoured only in DONE/ERROR)
//  lut_index    out  IDX_W  LUT address, registered
//  lut_data     in   24     LUT entry, combinational from lut_index
//  lut_size     in   IDX_W  number of valid entries
//  i2c_req      out  1      write request, level-held until i2c_done
//  i2c_addr     out  16     register address, stable while i2c_req=1
//  i2c_data     out  8      register value, stable while i2c_req=1
//  i2c_done     in   1      one-cycle pulse: write finished
//  i2c_nack     in   1      qualified by i2c_done: 1 = slave NACKed
//  cfg_busy     out  1      sequence in progress
//  cfg_done     out  1      all entries written; held until next run
//  cfg_err      out  1      entry failed MAX_RETRY times; held until next run
//  cfg_fail_idx out  IDX_W  index of the failed entry (valid while cfg_err=1)
// BEHAVIOUR
//  - Reset: all outputs 0; state INIT; delay counter 0; retry counter 0.
//  - States: INIT -> FETCH -> ISSUE -> WAIT -> HOLD -> FETCH ... -> DONE | ERROR.
//  - INIT: cfg_busy=1, count INIT_DLY cycles, then FETCH with lut_index=0.
//    If lut_size==0: go straight to DONE.
//  - FETCH (1 cycle): latch lut_data[23:8] into i2c_addr and lut_data[7:0] into i2c_data.
//  - ISSUE: assert i2c_req on the next cycle; go to WAIT.
//  - WAIT: hold i2c_req, i2c_addr and i2c_data until i2c_done=1.
//    i2c_req drops on the cycle after i2c_done.
//  - On i2c_done with i2c_nack=0: clear the retry counter.
//    - i2c_addr==16'h0103: HOLD for SRST_DLY cycles.
//    - Otherwise: HOLD for GAP_DLY cycles.
//    - After HOLD: if lut_index==lut_size-1, go to DONE; else lut_index+1 and FETCH.
//  - On i2c_done with i2c_nack=1: retry+1.
//    - If retry < MAX_RETRY: HOLD for GAP_DLY, then ISSUE again with the same index and data (no refetch).
//    - Else: go to ERROR with cfg_fail_idx=lut_index.
//  - DONE: cfg_done=1, cfg_busy=0. ERROR: cfg_err=1, cfg_busy=0. i2c_req=0 in both.
//  - cfg_start in DONE/ERROR: clear done/err/retry, set lut_index=0, go to FETCH (no INIT delay); cfg_busy=1 next cycle.
//  - cfg_start in any other state: ignored.
//  - i2c_done outside WAIT: ignored. i2c_done and cfg_start in the same cycle: the WAIT rule wins.
//  - Delay counters count 0..N-1 and then exit; N=0 behaves as N=1 (one cycle).
//  - lut_index never exceeds lut_size-1; no wrap.
//  - rst_n low mid-write: immediate return to reset values. The I2C master is reset by the same rst_n.
// TESTING (INIT_DLY=10, SRST_DLY=20, GAP_DLY=2, MAX_RETRY=2, I2C model returns done 5 cycles after req)
//  1. 4-entry LUT {0103/01, 0100/00, 3e01/45, 0100/01}
//     -> 4 writes in order; first i2c_req 12 clk after rst_n rise; >=20 idle clk after the 0103 write; cfg_done=1, cfg_busy=0.
//  2. NACK on entry 2, first attempt only
//     -> entry 2 written twice with identical addr/data; sequence completes; cfg_err=0.
//  3. NACK on entry 2, every attempt
//     -> exactly 2 attempts; cfg_err=1; cfg_fail_idx=2; no entry-3 write; i2c_req=0.
//  4. In DONE, pulse cfg_start -> rerun from index 0 with no INIT delay.
//     Pulse cfg_start mid-run -> no effect; write count unchanged.
//  5. lut_size=0 -> cfg_done after INIT with no i2c_req.
//     lut_size=1 -> exactly one write, then done.
//  6. Drop rst_n during WAIT of entry 1 -> all outputs 0 immediately; after release, full rerun from INIT.

Source files
------------

// File: rtl/i2c_sensor_cfg_sequencer.sv
// Walks the sensor register-config LUT and issues one 16-bit-address I2C register write per entry,
// with power-up, soft-reset settle and inter-write delays plus bounded NACK retries.
module i2c_sensor_cfg_sequencer #(
    parameter int unsigned IDX_W     = 9,
    parameter int unsigned INIT_DLY  = 500000,
    parameter int unsigned SRST_DLY  = 250000,
    parameter int unsigned GAP_DLY   = 100,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned DLY_W     = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_start,
    output logic [IDX_W-1:0] lut_index,
    input  logic [23:0]      lut_data,
    input  logic [IDX_W-1:0] lut_size,
    output logic             i2c_req,
    output logic [15:0]      i2c_addr,
    output logic [7:0]       i2c_data,
    input  logic             i2c_done,
    input  logic             i2c_nack,
    output logic             cfg_busy,
    output logic             cfg_done,
    output logic             cfg_err,
    output logic [IDX_W-1:0] cfg_fail_idx
);

    localparam int unsigned RETRY_W = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;

    // Terminal counts; a zero delay still spends one cycle in its state.
    localparam logic [DLY_W-1:0] INIT_LAST = (INIT_DLY == 0) ? '0 : DLY_W'(INIT_DLY - 1);
    localparam logic [DLY_W-1:0] SRST_LAST = (SRST_DLY == 0) ? '0 : DLY_W'(SRST_DLY - 1);
    localparam logic [DLY_W-1:0] GAP_LAST  = (GAP_DLY == 0) ? '0 : DLY_W'(GAP_DLY - 1);

    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);
    localparam logic [15:0]        SRST_REG   = 16'h0103;

    typedef enum logic [2:0] {
        StInit,
        StFetch,
        StIssue,
        StWait,
        StHold,
        StDone,
        StError
    } state_e;

    state_e             state_q, state_d;
    logic [DLY_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [15:0]        addr_q, addr_d;
    logic [7:0]         data_q, data_d;
    logic               req_q, req_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [IDX_W-1:0]   fail_idx_q, fail_idx_d;
    logic               srst_q, srst_d;
    logic               retry_pend_q, retry_pend_d;
    logic [DLY_W-1:0]   hold_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StInit;
            cnt_q        <= '0;
            retry_q      <= '0;
            idx_q        <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            req_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            fail_idx_q   <= '0;
            srst_q       <= 1'b0;
            retry_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            idx_q        <= idx_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            req_q        <= req_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            fail_idx_q   <= fail_idx_d;
            srst_q       <= srst_d;
            retry_pend_q <= retry_pend_d;
        end
    end

    assign hold_last = srst_q ? SRST_LAST : GAP_LAST;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        retry_d      = retry_q;
        idx_d        = idx_q;
        addr_d       = addr_q;
        data_d       = data_q;
        req_d        = req_q;
        busy_d       = busy_q;
        done_d       = done_q;
        err_d        = err_q;
        fail_idx_d   = fail_idx_q;
        srst_d       = srst_q;
        retry_pend_d = retry_pend_q;

        case (state_q)
            StInit: begin
                busy_d = 1'b1;
                if (cnt_q == INIT_LAST) begin
                    cnt_d = '0;
                    idx_d = '0;
                    if (lut_size == '0) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = StFetch;
                    end
                end else begin
                    cnt_d = cnt_q + DLY_W'(1);
                end
            end

            StFetch: begin
                addr_d  = lut_data[23:8];
                data_d  = lut_data[7:0];
                state_d = StIssue;
            end

            StIssue: begin
                req_d   = 1'b1;
                state_d = StWait;
            end

            StWait: begin
                if (i2c_done) begin
                    req_d = 1'b0;
                    cnt_d = '0;
                    if (!i2c_nack) begin
                        retry_d      = '0;
                        retry_pend_d = 1'b0;
                        srst_d       = (addr_q == SRST_REG);
                        state_d      = StHold;
                    end else begin
                        retry_d = retry_q + RETRY_W'(1);
                        if (retry_q >= RETRY_LAST) begin
                            state_d    = StError;
                            err_d      = 1'b1;
                            busy_d     = 1'b0;
                            fail_idx_d = idx_q;
                        end else begin
                            srst_d       = 1'b0;
                            retry_pend_d = 1'b1;
                            state_d      = StHold;
                        end
                    end
                end
            end

            StHold: begin
                if (cnt_q == hold_last) begin
                    cnt_d = '0;
                    if (retry_pend_q) begin
                        // Retry reuses the latched address/data; no refetch.
                        state_d = StIssue;
                    end else if (idx_q == lut_size - IDX_W'(1)) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = StFetch;
                    end
                end else begin
                    cnt_d = cnt_q + DLY_W'(1);
                end
            end

            StDone, StError: begin
                if (cfg_start) begin
                    done_d       = 1'b0;
                    err_d        = 1'b0;
                    retry_d      = '0;
                    retry_pend_d = 1'b0;
                    idx_d        = '0;
                    fail_idx_d   = '0;
                    cnt_d        = '0;
                    busy_d       = 1'b1;
                    state_d      = StFetch;
                end
            end

            default: state_d = StInit;
        endcase
    end

    assign lut_index    = idx_q;
    assign i2c_req      = req_q;
    assign i2c_addr     = addr_q;
    assign i2c_data     = data_q;
    assign cfg_busy     = busy_q;
    assign cfg_done     = done_q;
    assign cfg_err      = err_q;
    assign cfg_fail_idx = fail_idx_q;

endmodule

// File: tb/tb_i2c_sensor_cfg_sequencer.sv
// Bench for i2c_sensor_cfg_sequencer: an I2C master model answers writes, and a timing-level
// reference model predicts every write (addr, data, index, start cycle) and the final status.
module tb_i2c_sensor_cfg_sequencer;

    localparam int unsigned IDX_W     = 9;
    localparam int unsigned INIT_DLY  = 10;
    localparam int unsigned SRST_DLY  = 20;
    localparam int unsigned GAP_DLY   = 2;
    localparam int unsigned MAX_RETRY = 2;
    localparam int unsigned DLY_W     = 20;
    localparam int          DONE_LAT  = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             cfg_start = 1'b0;
    logic [IDX_W-1:0] lut_index;
    logic [23:0]      lut_data;
    logic [IDX_W-1:0] lut_size = '0;
    logic             i2c_req;
    logic [15:0]      i2c_addr;
    logic [7:0]       i2c_data;
    logic             i2c_done = 1'b0;
    logic             i2c_nack = 1'b0;
    logic             cfg_busy, cfg_done, cfg_err;
    logic [IDX_W-1:0] cfg_fail_idx;

    logic [23:0] lut_mem [512];
    int          nack_cnt [512];
    int          att [512];

    int log_addr[$], log_data[$], log_idx[$], log_t[$];
    int exp_addr[$], exp_data[$], exp_idx[$], exp_t[$];
    int exp_end, exp_fail, end_cyc, stab_err, cyc;
    bit exp_err, ended, seen_busy;
    int checks = 0;
    int failures = 0;

    i2c_sensor_cfg_sequencer #(
        .IDX_W(IDX_W), .INIT_DLY(INIT_DLY), .SRST_DLY(SRST_DLY),
        .GAP_DLY(GAP_DLY), .MAX_RETRY(MAX_RETRY), .DLY_W(DLY_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .lut_index(lut_index),
        .lut_data(lut_data), .lut_size(lut_size), .i2c_req(i2c_req), .i2c_addr(i2c_addr),
        .i2c_data(i2c_data), .i2c_done(i2c_done), .i2c_nack(i2c_nack), .cfg_busy(cfg_busy),
        .cfg_done(cfg_done), .cfg_err(cfg_err), .cfg_fail_idx(cfg_fail_idx)
    );

    assign lut_data = lut_mem[lut_index];

    always #5 clk = ~clk;

    // Counts rising edges since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Monitor plus I2C master model: done (with optional NACK) DONE_LAT cycles after req.
    initial begin
        bit          prev_req;
        bit          macked;
        int          mcnt;
        int          ix;
        logic [15:0] pa;
        logic [7:0]  pd;
        prev_req = 0; macked = 0; mcnt = 0; pa = '0; pd = '0;
        forever begin
            @(negedge clk);
            i2c_done = 1'b0;
            i2c_nack = 1'b0;
            if (!rst_n) begin
                prev_req = 0; macked = 0; mcnt = 0;
                continue;
            end
            if (cfg_busy) seen_busy = 1;
            if (seen_busy && (cfg_done || cfg_err) && !ended) begin
                ended   = 1;
                end_cyc = cyc;
            end
            if (i2c_req && !prev_req) begin
                log_addr.push_back(int'(i2c_addr));
                log_data.push_back(int'(i2c_data));
                log_idx.push_back(int'(lut_index));
                log_t.push_back(cyc);
            end
            if (i2c_req && prev_req && (i2c_addr != pa || i2c_data != pd)) stab_err++;
            prev_req = i2c_req; pa = i2c_addr; pd = i2c_data;
            if (i2c_req && !macked) begin
                mcnt++;
                if (mcnt == DONE_LAT) begin
                    ix       = int'(lut_index);
                    i2c_done = 1'b1;
                    i2c_nack = (att[ix] < nack_cnt[ix]);
                    att[ix]++;
                    mcnt     = 0;
                    macked   = 1;
                end
            end else if (!i2c_req) begin
                macked = 0;
            end
        end
    end

    task automatic clear_run();
        log_addr.delete(); log_data.delete(); log_idx.delete(); log_t.delete();
        for (int i = 0; i < 512; i++) att[i] = 0;
        ended = 0; seen_busy = 0; stab_err = 0;
    endtask

    function automatic int eff(input int n);
        return (n == 0) ? 1 : n;
    endfunction

    // t0 = edge on which the first fetch begins; each write's req rises two edges after its fetch.
    task automatic build_model(input int t0, input int size);
        int t, n;
        exp_addr.delete(); exp_data.delete(); exp_idx.delete(); exp_t.delete();
        exp_err = 0; exp_fail = 0;
        if (size == 0) begin
            exp_end = t0;
            return;
        end
        t = t0 + 2;
        for (int i = 0; i < size; i++) begin
            for (int a = 0; a < MAX_RETRY; a++) begin
                exp_addr.push_back(int'(lut_mem[i][23:8]));
                exp_data.push_back(int'(lut_mem[i][7:0]));
                exp_idx.push_back(i);
                exp_t.push_back(t);
                if (a < nack_cnt[i]) begin
                    if (a + 1 >= MAX_RETRY) begin
                        exp_err  = 1;
                        exp_fail = i;
                        exp_end  = t + DONE_LAT;
                        return;
                    end
                    t = t + DONE_LAT + eff(GAP_DLY) + 1;
                end else begin
                    n = (lut_mem[i][23:8] == 16'h0103) ? eff(SRST_DLY) : eff(GAP_DLY);
                    if (i == size - 1) begin
                        exp_end = t + DONE_LAT + n;
                        return;
                    end
                    t = t + DONE_LAT + n + 2;
                    break;
                end
            end
        end
    endtask

    task automatic start_reset(output int t0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        clear_run();
        rst_n = 1'b1;
        t0 = INIT_DLY;
    endtask

    task automatic start_restart(output int t0);
        @(negedge clk);
        clear_run();
        cfg_start = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    task automatic verify(input string name);
        int n;
        for (int k = 0; k < 20000 && !ended; k++) @(negedge clk);
        check({name, ":finished"}, int'(ended), 1);
        repeat (40) @(negedge clk);
        check({name, ":nwrites"}, log_t.size(), exp_t.size());
        n = (log_t.size() < exp_t.size()) ? log_t.size() : exp_t.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s:w%0d_addr", name, i), log_addr[i], exp_addr[i]);
            check($sformatf("%s:w%0d_data", name, i), log_data[i], exp_data[i]);
            check($sformatf("%s:w%0d_idx", name, i), log_idx[i], exp_idx[i]);
            check($sformatf("%s:w%0d_cycle", name, i), log_t[i], exp_t[i]);
        end
        check({name, ":end_cycle"}, end_cyc, exp_end);
        check({name, ":done"}, int'(cfg_done), int'(!exp_err));
        check({name, ":err"}, int'(cfg_err), int'(exp_err));
        check({name, ":busy"}, int'(cfg_busy), 0);
        check({name, ":req"}, int'(i2c_req), 0);
        check({name, ":stable"}, stab_err, 0);
        if (exp_err) check({name, ":fail_idx"}, int'(cfg_fail_idx), exp_fail);
    endtask

    task automatic load_s1();
        lut_mem[0] = 24'h0103_01;
        lut_mem[1] = 24'h0100_00;
        lut_mem[2] = 24'h3e01_45;
        lut_mem[3] = 24'h0100_01;
        lut_size = 9'd4;
        for (int i = 0; i < 512; i++) nack_cnt[i] = 0;
    endtask

    task automatic check_zero(input string name);
        check({name, ":req"}, int'(i2c_req), 0);
        check({name, ":addr"}, int'(i2c_addr), 0);
        check({name, ":data"}, int'(i2c_data), 0);
        check({name, ":index"}, int'(lut_index), 0);
        check({name, ":busy"}, int'(cfg_busy), 0);
        check({name, ":done"}, int'(cfg_done), 0);
        check({name, ":err"}, int'(cfg_err), 0);
        check({name, ":fail_idx"}, int'(cfg_fail_idx), 0);
    endtask

    initial begin
        int t0;
        int k;
        for (int i = 0; i < 512; i++) begin
            lut_mem[i] = '0;
            nack_cnt[i] = 0;
            att[i] = 0;
        end
        load_s1();
        #1 rst_n = 1'b0;
        #2 check_zero("reset");

        // 1: basic 4-entry run from reset
        start_reset(t0);
        build_model(t0, 4);
        verify("basic");
        if (log_t.size() >= 2)
            check("srst_idle_ge", int'(log_t[1] - log_t[0] - DONE_LAT >= SRST_DLY), 1);
        else
            check("srst_idle_ge", 0, 1);

        // 2: single NACK on entry 2, restarted from DONE
        nack_cnt[2] = 1;
        start_restart(t0);
        build_model(t0, 4);
        verify("nack_once");

        // 3: persistent NACK on entry 2
        nack_cnt[2] = MAX_RETRY;
        start_restart(t0);
        build_model(t0, 4);
        verify("nack_always");

        // 4: restart from ERROR, with an ignored cfg_start mid-run
        nack_cnt[2] = 0;
        start_restart(t0);
        build_model(t0, 4);
        repeat (30) @(negedge clk);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        verify("midrun_start");

        // 5: empty LUT from reset, then single entry
        lut_size = 9'd0;
        start_reset(t0);
        build_model(t0, 0);
        verify("size0");
        lut_mem[0] = 24'h3e01_a5;
        lut_size = 9'd1;
        start_restart(t0);
        build_model(t0, 1);
        verify("size1");

        // 6: reset during WAIT of entry 1, then full rerun
        load_s1();
        start_restart(t0);
        for (k = 0; k < 2000 && !(i2c_req && lut_index == 9'd1); k++) @(negedge clk);
        check("rst6_reached_wait", int'(i2c_req && lut_index == 9'd1), 1);
        #2 rst_n = 1'b0;
        #1 check_zero("rst6");
        start_reset(t0);
        build_model(t0, 4);
        verify("rerun_after_rst");

        // Randomized LUTs and NACK patterns
        for (int r = 0; r < 6; r++) begin
            int sz;
            int v;
            sz = $urandom_range(1, 8);
            for (int i = 0; i < 512; i++) nack_cnt[i] = 0;
            for (int i = 0; i < sz; i++) begin
                lut_mem[i] = 24'($urandom);
                if ($urandom_range(0, 3) == 0) lut_mem[i][23:8] = 16'h0103;
                v = $urandom_range(0, 19);
                nack_cnt[i] = (v < 14) ? 0 : (v < 18) ? 1 : MAX_RETRY;
            end
            lut_size = IDX_W'(sz);
            start_restart(t0);
            build_model(t0, sz);
            verify($sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
